// File: rtl/io_mouse_fifo.sv
// Mouse packet FIFO with a 6-byte memory-mapped register window on a shared tri-state bus.
// Packets {status, X, Y, Z} queue up here until the CPU pops them; an optional interrupt announces arrivals.
module io_mouse_fifo #(
  parameter logic [7:0] BASE_ADDR  = 8'hA0,
  parameter int         FIFO_DEPTH = 4,     // 2, 4, 8 or 16
  parameter bit         HAS_Z      = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  input  logic       PKT_VALID,
  input  logic [3:0] PKT_STATUS,
  input  logic [7:0] PKT_X,
  input  logic [7:0] PKT_Y,
  input  logic [7:0] PKT_Z
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [3:0] status;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] z;
  } pkt_t;

  pkt_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          ie_q, ie_d;
  logic          irq_q, irq_d;
  logic          oe_q, oe_d;
  logic [7:0]    dout_q, dout_d;

  // Offset is computed with 8-bit wrap so a window near 8'hFF still decodes correctly.
  logic [7:0] off;
  logic       in_win, rd_en, wr_ctrl;
  logic [7:0] wdata;
  logic       pop_req, flush, clr_ovf;
  logic       empty, full, pop_en, push_en, ovf_set;
  pkt_t       pkt_in, head;
  logic [4:0] cnt5;
  logic [7:0] rd_val;
  logic       unused_wdata;

  assign off     = BUS_ADDR - BASE_ADDR;
  assign in_win  = (off < 8'd6);
  assign rd_en   = in_win && !BUS_WE;
  assign wr_ctrl = in_win && BUS_WE && (off == 8'd5);
  assign wdata   = BUS_DATA;
  assign unused_wdata = &{1'b0, wdata[7:4]};

  assign pop_req = wr_ctrl && wdata[1];
  assign flush   = wr_ctrl && wdata[2];
  assign clr_ovf = wr_ctrl && wdata[3];

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));

  // A flush discards everything in the cycle, including a simultaneous pop or push.
  assign pop_en  = pop_req && !empty && !flush;
  assign push_en = PKT_VALID && !flush && (!full || pop_en);
  assign ovf_set = PKT_VALID && !flush && full && !pop_en;

  assign pkt_in.status = PKT_STATUS;
  assign pkt_in.x      = PKT_X;
  assign pkt_in.y      = PKT_Y;
  assign pkt_in.z      = HAS_Z ? PKT_Z : 8'h00;

  assign head = mem_q[rd_ptr_q];
  assign cnt5 = 5'(cnt_q);

  always_comb begin
    rd_val = 8'h00;
    case (off)
      8'd0: rd_val = empty ? 8'h00 : {4'b0, head.status};
      8'd1: rd_val = empty ? 8'h00 : head.x;
      8'd2: rd_val = empty ? 8'h00 : head.y;
      8'd3: rd_val = empty ? 8'h00 : head.z;
      8'd4: rd_val = {ovf_q, empty, full, 1'b0, cnt5[3:0]};
      8'd5: rd_val = {7'b0, ie_q};
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ie_d     = ie_q;
    irq_d    = irq_q;
    oe_d     = rd_en;
    dout_d   = rd_en ? rd_val : dout_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(push_en) - CW'(pop_en);
    end

    // Set has priority over clear for both sticky flags.
    if (clr_ovf) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    if (wr_ctrl) ie_d = wdata[0];

    if (BUS_INTERRUPT_ACK)      irq_d = 1'b0;
    if (wr_ctrl && !wdata[0])   irq_d = 1'b0;
    if (push_en && ie_q)        irq_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
      oe_q     <= 1'b0;
      dout_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
      oe_q     <= oe_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is left unreset; entries are only ever read after being written.
  always_ff @(posedge CLK) begin
    if (push_en && !RESET) mem_q[wr_ptr_q] <= pkt_in;
  end

  assign BUS_DATA            = oe_q ? dout_q : 8'hzz;
  assign BUS_INTERRUPT_RAISE = irq_q;

endmodule

// File: tb/tb_io_mouse_fifo.sv
// Directed bench for io_mouse_fifo: a table of bus/packet vectors plus hand sequences for async reset and HAS_Z=0.
module tb_io_mouse_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic       we = 1'b0, drv = 1'b0, pv = 1'b0, ack = 1'b0;
  logic [7:0] wd = 8'h00;
  logic [3:0] st = 4'h0;
  logic [7:0] px = 8'h00, py = 8'h00, pz = 8'h00;
  wire  [7:0] bus, bus2;
  logic       raise, raise2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign bus  = drv ? wd : 8'hzz;
  assign bus2 = drv ? wd : 8'hzz;

  io_mouse_fifo #(.BASE_ADDR(8'hA0), .FIFO_DEPTH(4), .HAS_Z(1'b1)) dut (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus), .BUS_ADDR(addr), .BUS_WE(we),
    .BUS_INTERRUPT_RAISE(raise), .BUS_INTERRUPT_ACK(ack), .PKT_VALID(pv),
    .PKT_STATUS(st), .PKT_X(px), .PKT_Y(py), .PKT_Z(pz));

  io_mouse_fifo #(.BASE_ADDR(8'hA0), .FIFO_DEPTH(4), .HAS_Z(1'b0)) dut_noz (
    .CLK(clk), .RESET(rst), .BUS_DATA(bus2), .BUS_ADDR(addr), .BUS_WE(we),
    .BUS_INTERRUPT_RAISE(raise2), .BUS_INTERRUPT_ACK(ack), .PKT_VALID(pv),
    .PKT_STATUS(st), .PKT_X(px), .PKT_Y(py), .PKT_Z(pz));

  typedef struct {
    logic [7:0]  addr;
    logic        we;
    logic [7:0]  wd;
    logic        pv;
    logic [27:0] pkt;
    logic        ack;
    logic        chk_d;
    logic [7:0]  exp_d;
    logic        chk_r;
    logic        exp_r;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] a, input logic w, input logic [7:0] d, input logic p,
                     input logic [27:0] pk, input logic k, input logic cd, input logic [7:0] ed,
                     input logic cr, input logic er);
    vec_t v;
    v.addr = a; v.we = w; v.wd = d; v.pv = p; v.pkt = pk; v.ack = k;
    v.chk_d = cd; v.exp_d = ed; v.chk_r = cr; v.exp_r = er;
    tbl.push_back(v);
  endtask

  task automatic R(input logic [7:0] a, input logic [7:0] e);
    add(a, 1'b0, 8'h00, 1'b0, 28'h0, 1'b0, 1'b1, e, 1'b0, 1'b0);
  endtask
  task automatic W(input logic [7:0] a, input logic [7:0] d);
    add(a, 1'b1, d, 1'b0, 28'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic Wr(input logic [7:0] a, input logic [7:0] d, input logic r);
    add(a, 1'b1, d, 1'b0, 28'h0, 1'b0, 1'b0, 8'h00, 1'b1, r);
  endtask
  task automatic P(input logic [27:0] pk);
    add(8'h00, 1'b0, 8'h00, 1'b1, pk, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask
  task automatic Pr(input logic [27:0] pk, input logic r);
    add(8'h00, 1'b0, 8'h00, 1'b1, pk, 1'b0, 1'b0, 8'h00, 1'b1, r);
  endtask
  task automatic WP(input logic [7:0] d, input logic [27:0] pk, input logic r);
    add(8'hA5, 1'b1, d, 1'b1, pk, 1'b0, 1'b0, 8'h00, 1'b1, r);
  endtask
  task automatic A();
    add(8'h00, 1'b0, 8'h00, 1'b0, 28'h0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic idle();
    addr = 8'h00; we = 1'b0; drv = 1'b0; wd = 8'h00; pv = 1'b0; ack = 1'b0;
  endtask

  // Inputs change 1ns after a rising edge; results are sampled 1ns after the next one.
  task automatic apply(input vec_t v, input int i);
    addr = v.addr; we = v.we; drv = v.we; wd = v.wd; pv = v.pv; ack = v.ack;
    {st, px, py, pz} = v.pkt;
    @(posedge clk); #1;
    idle();
    if (v.chk_d) chk($sformatf("vec%0d_data", i), bus, v.exp_d);
    if (v.chk_r) chk($sformatf("vec%0d_raise", i), {7'b0, raise}, {7'b0, v.exp_r});
    @(posedge clk); #1;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i], i);
    tbl.delete();
  endtask

  initial begin
    idle();
    #1;
    chk("reset_raise_no_clock", {7'b0, raise}, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state of every register.
    R(8'hA0, 8'h00); R(8'hA1, 8'h00); R(8'hA2, 8'h00);
    R(8'hA3, 8'h00); R(8'hA4, 8'h40); R(8'hA5, 8'h00);
    add(8'h00, 1'b0, 8'h00, 1'b0, 28'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Single packet with interrupt enabled, then ack and pop.
    W(8'hA5, 8'h01);
    Pr(28'h5_12_F3_01, 1'b1);
    R(8'hA0, 8'h05); R(8'hA1, 8'h12); R(8'hA2, 8'hF3); R(8'hA3, 8'h01);
    R(8'hA4, 8'h01); R(8'hA5, 8'h01);
    A();
    W(8'hA5, 8'h03);
    R(8'hA4, 8'h40);

    // Overflow: five pushes into a depth-4 FIFO, drain in order, clear OVF.
    P(28'h1_11_21_31); P(28'h2_12_22_32); P(28'h3_13_23_33); P(28'h4_14_24_34);
    P(28'h8_15_25_35);
    R(8'hA4, 8'hA4);
    R(8'hA0, 8'h01);
    R(8'hA1, 8'h11); W(8'hA5, 8'h03);
    R(8'hA1, 8'h12); W(8'hA5, 8'h03);
    R(8'hA1, 8'h13); W(8'hA5, 8'h03);
    R(8'hA1, 8'h14); W(8'hA5, 8'h03);
    R(8'hA4, 8'hC0);
    R(8'hA0, 8'h00);
    W(8'hA5, 8'h09);
    R(8'hA4, 8'h40);
    A();

    // Full FIFO with simultaneous push and pop.
    P(28'h1_41_51_61); P(28'h2_42_52_62); P(28'h3_43_53_63); P(28'h4_44_54_64);
    R(8'hA4, 8'h24);
    A();
    WP(8'h03, 28'h5_45_55_65, 1'b1);
    R(8'hA4, 8'h24);
    R(8'hA1, 8'h42); W(8'hA5, 8'h03);
    R(8'hA1, 8'h43); W(8'hA5, 8'h03);
    R(8'hA1, 8'h44); W(8'hA5, 8'h03);
    R(8'hA1, 8'h45); W(8'hA5, 8'h03);
    R(8'hA4, 8'h40);
    A();

    // Flush with a simultaneous push: push discarded, no interrupt.
    P(28'h1_01_02_03); P(28'h2_04_05_06); P(28'h3_07_08_09);
    A();
    WP(8'h05, 28'hF_AA_BB_CC, 1'b0);
    R(8'hA4, 8'h40);

    // Interrupt enable / ack interactions.
    W(8'hA5, 8'h01);
    Pr(28'h1_00_00_00, 1'b1);
    Wr(8'hA5, 8'h00, 1'b0);
    W(8'hA5, 8'h01);
    WP(8'h00, 28'h2_00_00_00, 1'b1);
    A();
    Pr(28'h3_00_00_00, 1'b0);
    W(8'hA5, 8'h01);
    add(8'h00, 1'b0, 8'h00, 1'b1, 28'h4_00_00_00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
    A();
    R(8'hA4, 8'h24);

    // OVF set beats clear; empty pop ignored; writes to read-only offsets ignored.
    WP(8'h08, 28'h5_00_00_00, 1'b0);
    R(8'hA4, 8'hA4);
    W(8'hA5, 8'h08);
    R(8'hA4, 8'h24);
    W(8'hA5, 8'h04);
    W(8'hA5, 8'h02);
    R(8'hA4, 8'h40);
    P(28'h6_66_77_88);
    R(8'hA4, 8'h01);
    W(8'hA4, 8'hFF); W(8'hA0, 8'hFF); W(8'hA3, 8'hFF);
    R(8'hA4, 8'h01); R(8'hA0, 8'h06); R(8'hA3, 8'h88);
    run_tbl();

    // Asynchronous reset mid-read with count=3 and interrupt pending.
    W(8'hA5, 8'h01);
    P(28'h7_01_01_01); P(28'h7_02_02_02);
    run_tbl();
    chk("pre_reset_raise", {7'b0, raise}, 8'h01);
    addr = 8'hA4;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("async_reset_raise", {7'b0, raise}, 8'h00);
    chk("async_reset_raise_noz", {7'b0, raise2}, 8'h00);
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    R(8'hA4, 8'h40);
    R(8'hA5, 8'h00);
    run_tbl();

    // Push on the very first edge after reset release; HAS_Z=0 masks the Z byte.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pv = 1'b1; {st, px, py, pz} = 28'h9_AB_CD_EF;
    @(posedge clk); #1;
    idle();
    R(8'hA4, 8'h01);
    run_tbl();
    addr = 8'hA3;
    @(posedge clk); #1;
    idle();
    chk("hasz_a3", bus, 8'hEF);
    chk("noz_a3", bus2, 8'h00);
    @(posedge clk); #1;
    addr = 8'hA1;
    @(posedge clk); #1;
    idle();
    chk("noz_a1", bus2, 8'hAB);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
